// File: rtl/if_id_skid_stage_pkg.sv
// Shared pipeline package for the IF/ID skid stage: state encoding,
// default bubble instruction, performance-counter width and a saturating
// increment helper.
package if_id_skid_stage_pkg;

  // Stage occupancy states
  localparam logic [1:0] ST_EMPTY = 2'd0;  // no valid entry
  localparam logic [1:0] ST_FULL  = 2'd1;  // main entry valid
  localparam logic [1:0] ST_SKID  = 2'd2;  // main and skid entries valid

  // MIPS sll $0,$0,0 used as the downstream bubble
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Width of the optional performance counters
  localparam int unsigned PERF_CNT_W = 32;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    if (v == {PERF_CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/if_id_skid_stage_pipe_entry_reg.sv
// pipe_entry_reg: N-bit storage element with synchronous active-high
// reset (clears to 0) and a load enable. Holds its value bit-exact
// whenever load_i is low.
module pipe_entry_reg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] data_q;

  // Capture new data on load, otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= {N{1'b0}};
    end else if (load_i) begin
      data_q <= d_i;
    end else begin
      data_q <= data_q;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage: IF/ID pipeline register with valid/ready handshake,
// one-entry skid buffer, hazard stall (out_ready=0) and branch flush.
// Optional feature: define IF_ID_PERF_EN to add stall/bubble counters.
module if_id_skid_stage
  import if_id_skid_stage_pkg::*;
#(
  parameter int           N         = 32,
  parameter logic [N-1:0] NOP_INSTR = N'(NOP_INSTR_DEFAULT)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] IN_PC_Conter_Plus_4,
  input  logic [N-1:0] IN_Instruction_Wire,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] OUT_PC_Conter_Plus_4,
  output logic [N-1:0] OUT_Instruction_Wire
`ifdef IF_ID_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_count,
  output logic [PERF_CNT_W-1:0] bubble_count
`endif
);

  logic [1:0]   state_q, state_d;
  logic         in_ready_q, out_valid_q;
  logic         load_main_s, load_skid_s, main_from_skid_s;
  logic [N-1:0] main_pc_s, main_instr_s, skid_pc_s, skid_instr_s;
  logic [N-1:0] main_pc_d, main_instr_d;

  // Next-state and load decisions; flush overrides everything and drops
  // any upstream transfer, a downstream transfer needs no action here
  always_comb begin
    state_d          = state_q;
    load_main_s      = 1'b0;
    load_skid_s      = 1'b0;
    main_from_skid_s = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            load_main_s = 1'b1;
            state_d     = ST_FULL;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (in_valid && out_ready) begin
            load_main_s = 1'b1;
            state_d     = ST_FULL;
          end else if (in_valid) begin
            load_skid_s = 1'b1;
            state_d     = ST_SKID;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_FULL;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            load_main_s      = 1'b1;
            main_from_skid_s = 1'b1;
            state_d          = ST_FULL;
          end else begin
            state_d = ST_SKID;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State plus registered handshake flags derived from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_SKID);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  assign main_pc_d    = main_from_skid_s ? skid_pc_s    : IN_PC_Conter_Plus_4;
  assign main_instr_d = main_from_skid_s ? skid_instr_s : IN_Instruction_Wire;

  pipe_entry_reg #(.N(N)) u_main_pc (
    .clk(clk), .reset(reset), .load_i(load_main_s), .d_i(main_pc_d), .q_o(main_pc_s)
  );
  pipe_entry_reg #(.N(N)) u_main_instr (
    .clk(clk), .reset(reset), .load_i(load_main_s), .d_i(main_instr_d), .q_o(main_instr_s)
  );
  pipe_entry_reg #(.N(N)) u_skid_pc (
    .clk(clk), .reset(reset), .load_i(load_skid_s), .d_i(IN_PC_Conter_Plus_4), .q_o(skid_pc_s)
  );
  pipe_entry_reg #(.N(N)) u_skid_instr (
    .clk(clk), .reset(reset), .load_i(load_skid_s), .d_i(IN_Instruction_Wire), .q_o(skid_instr_s)
  );

  assign in_ready             = in_ready_q;
  assign out_valid            = out_valid_q;
  assign OUT_PC_Conter_Plus_4 = main_pc_s;
  assign OUT_Instruction_Wire = out_valid_q ? main_instr_s : NOP_INSTR;

`ifdef IF_ID_PERF_EN
  logic [PERF_CNT_W-1:0] stall_count_q, bubble_count_q;

  // Saturating stall and bubble counters; flush leaves them untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q  <= {PERF_CNT_W{1'b0}};
      bubble_count_q <= {PERF_CNT_W{1'b0}};
    end else begin
      stall_count_q  <= (out_valid_q && !out_ready) ? sat_inc(stall_count_q) : stall_count_q;
      bubble_count_q <= (!out_valid_q) ? sat_inc(bubble_count_q) : bubble_count_q;
    end
  end

  assign stall_count  = stall_count_q;
  assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Self-checking bench for if_id_skid_stage: a queue scoreboard models
// stage occupancy; entries are pushed on accepted upstream transfers and
// popped on downstream transfers, and outputs are compared every cycle.
module tb_if_id_skid_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = 32'h0;
  logic [31:0] in_instr = 32'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_count, bubble_count;
  int          exp_stall = 0;
  int          exp_bubble = 0;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [63:0] sb[$];
  logic [31:0] pc_ctr;

  if_id_skid_stage #(.N(32), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .IN_PC_Conter_Plus_4(in_pc),
    .IN_Instruction_Wire(in_instr),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .OUT_PC_Conter_Plus_4(out_pc),
    .OUT_Instruction_Wire(out_instr)
`ifdef IF_ID_PERF_EN
    ,
    .stall_count(stall_count),
    .bubble_count(bubble_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the scoreboard occupancy and head entry
  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, (sb.size() != 0)});
    chk({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, (sb.size() < 2)});
    if (sb.size() != 0) begin
      chk({tag, ".pc"}, out_pc, sb[0][63:32]);
      chk({tag, ".instr"}, out_instr, sb[0][31:0]);
    end else begin
      chk({tag, ".nop"}, out_instr, 32'h0000_0000);
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl, input string tag);
    logic up, dn;
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = rdy; flush = fl;
    up = v && (sb.size() < 2);
    dn = (sb.size() != 0) && rdy;
`ifdef IF_ID_PERF_EN
    if (sb.size() == 0) exp_bubble++;
    if ((sb.size() != 0) && !rdy) exp_stall++;
`endif
    @(posedge clk);
    #1;
    if (dn) void'(sb.pop_front());
    if (fl) sb.delete();
    else if (up) sb.push_back({pc, ins});
    in_valid = 1'b0; flush = 1'b0;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
`ifdef IF_ID_PERF_EN
    exp_stall = 0; exp_bubble = 0;
`endif
    chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, ".instr"}, out_instr, 32'h0000_0000);
    chk({tag, ".pc"}, out_pc, 32'h0000_0000);
  endtask

  initial begin
    // Reset values
    do_reset("reset");

    // Streaming at full rate
    cycle(1'b1, 32'h4, 32'h2008_0001, 1'b1, 1'b0, "stream0");
    cycle(1'b1, 32'h8, 32'h2009_0002, 1'b1, 1'b0, "stream1");
    cycle(1'b1, 32'hC, 32'h012A_4020, 1'b1, 1'b0, "stream2");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "stream3");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "stream4");

    // Stall into skid, 0xC held upstream, then drain without loss
    cycle(1'b1, 32'h4, 32'h2008_0001, 1'b0, 1'b0, "stall0");
    cycle(1'b1, 32'h8, 32'h2009_0002, 1'b0, 1'b0, "stall1");
    cycle(1'b1, 32'hC, 32'h012A_4020, 1'b0, 1'b0, "stall2");
    cycle(1'b1, 32'hC, 32'h012A_4020, 1'b1, 1'b0, "stall3");
    cycle(1'b1, 32'hC, 32'h012A_4020, 1'b1, 1'b0, "stall4");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "stall5");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "stall6");

    // Flush while in SKID, then a lone new entry
    cycle(1'b1, 32'h4, 32'h2008_0001, 1'b0, 1'b0, "fskid0");
    cycle(1'b1, 32'h8, 32'h2009_0002, 1'b0, 1'b0, "fskid1");
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "fskid_flush");
    cycle(1'b1, 32'h20, 32'h2010_0020, 1'b1, 1'b0, "fskid2");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "fskid3");

    // Flush with simultaneous in_valid, from EMPTY and from FULL
    cycle(1'b1, 32'h24, 32'h2011_0024, 1'b1, 1'b1, "fin_empty");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "fin_empty2");
    cycle(1'b1, 32'h28, 32'h2012_0028, 1'b0, 1'b0, "fin_full0");
    cycle(1'b1, 32'h2C, 32'h2013_002C, 1'b1, 1'b1, "fin_full1");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "fin_full2");

    // Reset while in SKID clears all held data
    cycle(1'b1, 32'h30, 32'h2014_0030, 1'b0, 1'b0, "rskid0");
    cycle(1'b1, 32'h34, 32'h2015_0034, 1'b0, 1'b0, "rskid1");
    do_reset("rskid_reset");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "rskid2");

    // Random traffic with occasional flushes
    pc_ctr = 32'h100;
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 3) != 0), pc_ctr, $urandom(),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0), "rand");
      pc_ctr = pc_ctr + 32'h4;
    end

`ifdef IF_ID_PERF_EN
    // 5 stalled cycles plus 2 empty cycles after reset
    do_reset("perf_reset");
    cycle(1'b1, 32'h4, 32'h2008_0001, 1'b0, 1'b0, "perf0");
    repeat (5) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "perf_stall");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "perf_drain");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "perf_empty");
    chk("stall_count", stall_count, 32'd5);
    chk("bubble_count", bubble_count, 32'd2);
    chk("stall_model", stall_count, exp_stall);
    chk("bubble_model", bubble_count, exp_bubble);
    // Saturation
    force dut.stall_count_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.stall_count_q;
    cycle(1'b1, 32'h8, 32'h2009_0002, 1'b0, 1'b0, "sat0");
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "sat1");
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "sat2");
    chk("stall_sat", stall_count, 32'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
